// File: rtl/stage_1_fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry hold buffer
// for decode back-pressure, and redirect-driven flush with late-response kill.
module stage_1_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_enable,
  input  logic [31:0] redirect_addr,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ready,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic        discard_out
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] hold_data_q;
  logic [XLEN-1:0] hold_pc_q;
  logic            hold_valid_q;
  logic            kill_q;

  logic            fire;
  logic            deliver_rsp;
  logic            deliver_hold;
  logic            capture_hold;
  logic            set_kill;
  logic            clr_kill;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect outranks every other event
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (!redirect_enable && imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_enable) begin
          state_d = imem_valid ? S_REQ : S_WAIT;
        end else if (imem_valid) begin
          if (kill_q || !stall) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_enable || !stall) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output / control decode
  always_comb begin
    imem_req_out  = 1'b0;
    imem_addr_out = pc_q;
    fire          = 1'b0;
    deliver_rsp   = 1'b0;
    deliver_hold  = 1'b0;
    capture_hold  = 1'b0;
    set_kill      = 1'b0;
    clr_kill      = 1'b0;
    case (state_q)
      S_REQ: begin
        imem_req_out = ~redirect_enable;
        fire         = ~redirect_enable & imem_ready;
      end
      S_WAIT: begin
        if (redirect_enable) begin
          // A response still in flight after the flush must be swallowed later
          set_kill = ~imem_valid;
          clr_kill = imem_valid;
        end else if (imem_valid) begin
          if (kill_q) begin
            clr_kill = 1'b1;
          end else if (!stall) begin
            deliver_rsp = 1'b1;
          end else begin
            capture_hold = 1'b1;
          end
        end
      end
      S_HOLD: begin
        deliver_hold = ~redirect_enable & ~stall & hold_valid_q;
      end
      default: begin
        imem_req_out = 1'b0;
      end
    endcase
  end

  // PC, request tracking and kill flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      kill_q     <= 1'b0;
    end else begin
      if (redirect_enable) begin
        pc_q <= redirect_addr;
      end else if (fire) begin
        pc_q <= pc_q + PC_STEP;
      end
      if (fire) begin
        fetch_pc_q <= pc_q;
      end
      if (set_kill) begin
        kill_q <= 1'b1;
      end else if (clr_kill) begin
        kill_q <= 1'b0;
      end
    end
  end

  // One-entry hold buffer for responses that arrive while decode is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= NOP_INSN;
      hold_pc_q    <= RESET_PC;
    end else if (redirect_enable) begin
      hold_valid_q <= 1'b0;
    end else if (capture_hold) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= imem_data;
      hold_pc_q    <= fetch_pc_q;
    end else if (deliver_hold) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Decode-facing registers: deliver, bubble, or hold under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_out <= NOP_INSN;
      pc_out          <= RESET_PC;
      discard_out     <= 1'b1;
    end else if (deliver_rsp) begin
      instruction_out <= imem_data;
      pc_out          <= fetch_pc_q;
      discard_out     <= 1'b0;
    end else if (deliver_hold) begin
      instruction_out <= hold_data_q;
      pc_out          <= hold_pc_q;
      discard_out     <= 1'b0;
    end else if (redirect_enable || !stall) begin
      instruction_out <= NOP_INSN;
      discard_out     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_1_fetch.sv
// Vector-table bench for stage_1_fetch with a delivery scoreboard.
module tb_stage_1_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D0  = 32'h00A0_0093;
  localparam logic [31:0] E0  = 32'h0020_0193;
  localparam logic [31:0] F0  = 32'h0030_0213;
  localparam logic [31:0] G0  = 32'h0040_0293;
  localparam logic [31:0] H0  = 32'h0060_0393;
  localparam logic [31:0] J0  = 32'h0050_0313;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_enable;
  logic [31:0] redirect_addr;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic        discard_out;

  stage_1_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_enable (redirect_enable),
    .redirect_addr   (redirect_addr),
    .imem_req_out    (imem_req_out),
    .imem_addr_out   (imem_addr_out),
    .imem_ready      (imem_ready),
    .imem_valid      (imem_valid),
    .imem_data       (imem_data),
    .instruction_out (instruction_out),
    .pc_out          (pc_out),
    .discard_out     (discard_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] ra;
    logic        rdy;
    logic        vld;
    logic [31:0] dat;
    logic        keep;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic        e_dis;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cur_row = -1;
  logic [31:0] last_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %h want %h", name, cur_row, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic s, input logic rd, input logic [31:0] ra,
                              input logic rdy, input logic v, input logic [31:0] d, input logic k,
                              input logic er, input logic [31:0] ea, input logic [31:0] ei,
                              input logic [31:0] ep, input logic ed);
    vec_t t;
    t = '{r, s, rd, ra, rdy, v, d, k, er, ea, ei, ep, ed};
    vecs.push_back(t);
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_underflow row %0d: got delivery %h want none", cur_row, instruction_out);
    end else begin
      e = sb.pop_front();
      chk("sb_ins", instruction_out, e.ins);
      chk("sb_pc", pc_out, e.pc);
    end
  endtask

  initial begin
    vec_t v;
    // streaming fetch 0,4,8
    add(0,0,0,0,1,0,0,0, 1,32'h0,NOP,32'h0,1);
    add(0,0,0,0,0,1,D0,1, 0,32'h4,D0,32'h0,0);
    add(0,0,0,0,1,0,0,0, 1,32'h4,NOP,32'h0,1);
    add(0,0,0,0,0,1,D0,1, 0,32'h8,D0,32'h4,0);
    add(0,0,0,0,1,0,0,0, 1,32'h8,NOP,32'h4,1);
    add(0,0,0,0,0,1,D0,1, 0,32'hC,D0,32'h8,0);
    // reset, then stall across the response for 0x4
    add(1,0,0,0,0,0,0,0, 1,32'h0,NOP,32'h0,1);
    add(0,0,0,0,1,0,0,0, 1,32'h0,NOP,32'h0,1);
    add(0,0,0,0,0,1,D0,1, 0,32'h4,D0,32'h0,0);
    add(0,1,0,0,1,0,0,0, 1,32'h4,D0,32'h0,0);
    add(0,1,0,0,0,1,E0,1, 0,32'h8,D0,32'h0,0);
    add(0,1,0,0,1,0,0,0, 0,32'h8,D0,32'h0,0);
    add(0,1,0,0,1,0,0,0, 0,32'h8,D0,32'h0,0);
    add(0,0,0,0,1,0,0,0, 0,32'h8,E0,32'h4,0);
    // redirect while waiting for 0x8, late response dropped
    add(0,0,0,0,1,0,0,0, 1,32'h8,NOP,32'h4,1);
    add(0,0,1,32'h100,0,0,0,0, 0,32'hC,NOP,32'h4,1);
    add(0,0,0,0,0,1,32'hDEAD_BEEF,0, 0,32'h100,NOP,32'h4,1);
    add(0,0,0,0,0,0,0,0, 1,32'h100,NOP,32'h4,1);
    add(0,0,0,0,1,0,0,0, 1,32'h100,NOP,32'h4,1);
    add(0,0,0,0,0,1,F0,1, 0,32'h104,F0,32'h100,0);
    // redirect with same-cycle response under stall, then pc wrap
    add(0,0,0,0,1,0,0,0, 1,32'h104,NOP,32'h100,1);
    add(0,1,1,32'hFFFF_FFFC,0,1,32'h0000_0BAD,0, 0,32'h108,NOP,32'h100,1);
    add(0,0,0,0,1,0,0,0, 1,32'hFFFF_FFFC,NOP,32'h100,1);
    add(0,0,0,0,0,1,G0,1, 0,32'h0,G0,32'hFFFF_FFFC,0);
    add(0,0,0,0,1,0,0,0, 1,32'h0,NOP,32'hFFFF_FFFC,1);
    // reset in WAIT, stale responses ignored
    add(1,0,0,0,0,0,0,0, 1,32'h0,NOP,32'h0,1);
    add(1,0,0,0,0,1,32'h0000_BAD1,0, 1,32'h0,NOP,32'h0,1);
    add(0,0,0,0,0,1,32'h0000_BAD2,0, 1,32'h0,NOP,32'h0,1);
    add(0,0,0,0,1,0,0,0, 1,32'h0,NOP,32'h0,1);
    add(0,0,0,0,0,1,H0,1, 0,32'h4,H0,32'h0,0);
    // redirect in REQ, then redirect while in HOLD
    add(0,0,1,32'h200,1,0,0,0, 0,32'h4,NOP,32'h0,1);
    add(0,0,0,0,1,0,0,0, 1,32'h200,NOP,32'h0,1);
    add(0,1,0,0,0,1,32'h55,0, 0,32'h204,NOP,32'h0,1);
    add(0,1,1,32'h300,0,0,0,0, 0,32'h204,NOP,32'h0,1);
    add(0,0,0,0,1,0,0,0, 1,32'h300,NOP,32'h0,1);
    add(0,0,0,0,0,1,J0,1, 0,32'h304,J0,32'h300,0);

    rst = 1'b1; stall = 1'b0; redirect_enable = 1'b0; redirect_addr = 32'h0;
    imem_ready = 1'b0; imem_valid = 1'b0; imem_data = 32'h0;
    #2;
    chk("rst_ins", instruction_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_dis", 32'(discard_out), 32'h1);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      cur_row = i;
      rst = v.rst; stall = v.st; redirect_enable = v.rd; redirect_addr = v.ra;
      imem_ready = v.rdy; imem_valid = v.vld; imem_data = v.dat;
      #1;
      chk("req", 32'(imem_req_out), 32'(v.e_req));
      chk("addr", imem_addr_out, v.e_addr);
      if (v.e_req && v.rdy && !v.rst) last_addr = v.e_addr;
      if (v.keep) sb.push_back('{v.dat, last_addr});
      @(posedge clk);
      #1;
      chk("ins", instruction_out, v.e_ins);
      chk("pc", pc_out, v.e_pc);
      chk("dis", 32'(discard_out), 32'(v.e_dis));
      if (!v.rst && !v.st && !v.e_dis) pop_check();
    end

    // stall with no redirect in REQ: outputs frozen, request still offered
    cur_row = 1000;
    rst = 1'b0; stall = 1'b1; redirect_enable = 1'b0; imem_ready = 1'b0; imem_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("hs_req", 32'(imem_req_out), 32'h1);
      chk("hs_addr", imem_addr_out, 32'h304);
      @(posedge clk);
      #1;
      chk("hs_ins", instruction_out, J0);
      chk("hs_pc", pc_out, 32'h300);
      chk("hs_dis", 32'(discard_out), 32'h0);
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("hs_bubble_ins", instruction_out, NOP);
    chk("hs_bubble_pc", pc_out, 32'h300);
    chk("hs_bubble_dis", 32'(discard_out), 32'h1);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_1_fetch.md
STAGE_1_FETCH -- requirements
Module: stage_1_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port stall  in  1  decode cannot accept a new instruction this cycle.
REQ-005 SHALL have port redirect_enable  in  1  taken jump/branch, so flush and refetch.
REQ-006 SHALL have port redirect_addr  in  32  new fetch address; only sampled when redirect_enable=1.
REQ-007 SHALL have port imem_req_out  out  1  fetch request valid.
REQ-008 SHALL have port imem_addr_out  out  32  fetch address, equal to pc.
REQ-009 SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-010 SHALL have port imem_valid  in  1  response data valid this cycle.
REQ-011 SHALL have port imem_data  in  32  instruction word.
REQ-012 SHALL have port instruction_out  out  32  registered instruction to decode.
REQ-013 SHALL have port pc_out  out  32  registered address of instruction_out.
REQ-014 SHALL have port discard_out  out  1  registered; 1 means instruction_out is a bubble.

Function
REQ-015 SHALL hold a 32-bit pc register, a one-entry hold buffer (data, pc) and a kill flag.
REQ-016 SHALL implement states REQ, WAIT and HOLD, with at most one memory request outstanding.
REQ-017 In REQ, SHALL drive imem_req_out = ~redirect_enable and imem_addr_out = pc; all other states drive imem_req_out=0.
REQ-018 In REQ, on the handshake (imem_req_out & imem_ready), SHALL latch fetch_pc <= pc, set pc <= pc+4 (mod 2^32, wrap without flag) and go to WAIT.
REQ-019 In WAIT, on imem_valid with kill=1, SHALL drop the data, clear kill and go to REQ.
REQ-020 In WAIT, on imem_valid with kill=0 and stall=0, SHALL load instruction_out=imem_data, pc_out=fetch_pc and discard_out=0, then go to REQ.
REQ-021 In WAIT, on imem_valid with kill=0 and stall=1, SHALL store the response in the hold buffer and go to HOLD.
REQ-022 In HOLD, on stall=0, SHALL move the hold buffer to the outputs with discard_out=0 and go to REQ.
REQ-023 When stall=0 and no instruction is delivered, SHALL load the output registers with instruction_out=32'h0000_0013 (NOP) and discard_out=1, with pc_out unchanged.
REQ-024 When stall=1 and redirect_enable=0, SHALL hold all output registers unchanged.
REQ-025 redirect_enable SHALL take priority over every other event in every state:
  - pc <= redirect_addr;
  - outputs <= bubble, regardless of stall;
  - hold buffer invalidated.
REQ-026 Redirect in WAIT without a same-cycle imem_valid SHALL set kill=1 and stay in WAIT.
REQ-027 Redirect coinciding with imem_valid SHALL drop that response and go to REQ with kill=0.
REQ-028 Redirect in HOLD SHALL go to REQ.
REQ-029 Redirect in REQ SHALL stay in REQ, issuing no request that cycle.
REQ-030 Redirect address bits [1:0] SHALL be used as given; misalignment is not checked.
REQ-031 Best-case throughput SHALL be one instruction per 2 cycles: single-cycle imem_ready plus response on the next cycle.
REQ-032 instruction_out SHALL appear 1 cycle after imem_valid.

Reset
REQ-033 On rst=1, the block SHALL immediately, without waiting for a clock edge:
  - set pc=RESET_PC, state=REQ, kill=0, hold buffer empty;
  - set instruction_out=32'h0000_0013, pc_out=RESET_PC, discard_out=1.
REQ-034 Reset asserted mid-request SHALL abandon the outstanding response.
REQ-035 A response arriving during or after reset without a new request SHALL be ignored.
REQ-036 Deasserting rst SHALL cause imem_req_out=1 with imem_addr_out=RESET_PC in the first cycle.

Verification
REQ-037 The bench SHALL cover reset release followed by imem that is always ready with a 1-cycle response of data=0x00A00093: pc_out sequence 0x0, 0x4, 0x8, with discard_out=0 on every delivery and 1 between deliveries.
REQ-038 The bench SHALL cover stall=1 held for 3 cycles while the response for 0x4 arrives: outputs keep 0x0 unchanged, then 0x4 appears the cycle after stall falls, and no request is issued during HOLD.
REQ-039 The bench SHALL cover redirect_enable=1 with redirect_addr=0x100 while WAIT for 0x8: the late response is dropped, the next imem_addr_out is 0x100, and discard_out=1 throughout.
REQ-040 The bench SHALL cover redirect coinciding with imem_valid and stall=1: the data is dropped, the outputs become a bubble despite the stall, and the next request goes to the redirect_addr.
REQ-041 The bench SHALL cover pc=0xFFFF_FFFC accepted: the next request goes to 0x0000_0000.
REQ-042 The bench SHALL cover rst pulsed while in WAIT, then the stale imem_valid: the stale response is ignored, the outputs stay at reset values, and the next request goes to RESET_PC.
